// File: rtl/color_scan_controller.sv
// Frame scan sequencer: walks image_memory addresses, counts colour detector hits
// after the detector latency, then picks the dominant colour. Optional COLOR_SCAN_THRESH_EN.
module color_scan_controller #(
  parameter int NUM_PIXELS  = 256,
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 16,
  parameter int DET_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef COLOR_SCAN_THRESH_EN
  input  logic [CNT_W-1:0]  min_count,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              red_detected,
  input  logic              green_detected,
  input  logic              blue_detected,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  red_count,
  output logic [CNT_W-1:0]  green_count,
  output logic [CNT_W-1:0]  blue_count,
  output logic [1:0]        dominant,
  output logic              red_led,
  output logic              green_led,
  output logic              blue_led
);

  // Handshake: start is a single-cycle request honoured only in IDLE with done low;
  // busy is high from the accepting edge until the edge that raises done.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(DET_LATENCY - 1);

  state_t                 state;
  logic [DET_LATENCY-1:0] vpipe;
  logic [2:0]             drain_cnt;
  logic [1:0]             dom_next;
  logic                   sample_ok;

`ifdef COLOR_SCAN_THRESH_EN
  logic [CNT_W-1:0]       min_q;
  logic [CNT_W-1:0]       win_cnt;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  // The pipe output marks the cycle whose detector flags belong to a real pixel.
  assign sample_ok = vpipe[DET_LATENCY-1];

  always_comb begin
    dom_next = 2'd0;
`ifdef COLOR_SCAN_THRESH_EN
    win_cnt = '0;
`endif
    if (red_count > green_count && red_count > blue_count) begin
      dom_next = 2'd1;
`ifdef COLOR_SCAN_THRESH_EN
      win_cnt = red_count;
`endif
    end else if (green_count > red_count && green_count > blue_count) begin
      dom_next = 2'd2;
`ifdef COLOR_SCAN_THRESH_EN
      win_cnt = green_count;
`endif
    end else if (blue_count > red_count && blue_count > green_count) begin
      dom_next = 2'd3;
`ifdef COLOR_SCAN_THRESH_EN
      win_cnt = blue_count;
`endif
    end
`ifdef COLOR_SCAN_THRESH_EN
    if (win_cnt < min_q) dom_next = 2'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      red_count   <= '0;
      green_count <= '0;
      blue_count  <= '0;
      dominant    <= 2'd0;
      red_led     <= 1'b0;
      green_led   <= 1'b0;
      blue_led    <= 1'b0;
      vpipe       <= '0;
      drain_cnt   <= 3'd0;
`ifdef COLOR_SCAN_THRESH_EN
      min_q       <= '0;
`endif
    end else begin
      done <= 1'b0;

      if (state == S_SCAN || state == S_DRAIN) begin
        vpipe[0] <= (state == S_SCAN);
        for (int i = 1; i < DET_LATENCY; i++) vpipe[i] <= vpipe[i-1];
        if (sample_ok) begin
          red_count   <= sat_inc(red_count, red_detected);
          green_count <= sat_inc(green_count, green_detected);
          blue_count  <= sat_inc(blue_count, blue_detected);
        end
      end

      case (state)
        S_IDLE: begin
          if (start && !done) begin
            red_count   <= '0;
            green_count <= '0;
            blue_count  <= '0;
            vpipe       <= '0;
            drain_cnt   <= 3'd0;
            mem_addr    <= '0;
            busy        <= 1'b1;
`ifdef COLOR_SCAN_THRESH_EN
            min_q       <= min_count;
`endif
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (mem_addr == LAST_ADDR) state <= S_DRAIN;
          else mem_addr <= mem_addr + 1'b1;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (drain_cnt == DRAIN_LAST) state <= S_DECIDE;
        end
        S_DECIDE: begin
          dominant  <= dom_next;
          red_led   <= (dom_next == 2'd1);
          green_led <= (dom_next == 2'd2);
          blue_led  <= (dom_next == 2'd3);
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/color_scan_controller.md
Name: color_scan_controller

Overview:
- Sequences one full-frame colour scan: issues pixel addresses to image_memory and accumulates red/green/blue detection flags from color_detection.
- Compensates for the detector's registered latency, then decides the dominant colour and drives the LEDs.
- Replaces the free-running address counter in top_color_detection with a start/done handshake, so frames can be rescanned on demand.

Parameters:
- NUM_PIXELS, 256: pixels per frame; addresses 0..NUM_PIXELS-1.
- ADDR_W, 16: address width.
- CNT_W, 16: colour counter width.
- DET_LATENCY, 1: cycles from address issue to valid detection flags (1 to 4).

Ports:
- clk  input  1: system clock.
- rst_n  input  1: asynchronous active-low reset.
- start  input  1: one-cycle request to begin a frame scan.
- mem_addr  output  ADDR_W: pixel address to image_memory.
- red_detected  input  1: detector flag for red.
- green_detected  input  1: detector flag for green.
- blue_detected  input  1: detector flag for blue.
- busy  output  1: high from scan accept until done.
- done  output  1: one-cycle pulse when results are valid.
- red_count  output  CNT_W: red pixel count for the last or current scan.
- green_count  output  CNT_W: green pixel count for the last or current scan.
- blue_count  output  CNT_W: blue pixel count for the last or current scan.
- dominant  output  2: 0 none, 1 red, 2 green, 3 blue.
- red_led  output  1: high when dominant==1.
- green_led  output  1: high when dominant==2.
- blue_led  output  1: high when dominant==3.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, mem_addr=0, busy=0, done=0, all counts=0, dominant=0, all LEDs=0, valid pipe cleared.
- FSM states: IDLE, SCAN, DRAIN, DECIDE, DONE.
- IDLE: start=1 -> clear counts and valid pipe, mem_addr=0, busy=1, go to SCAN. Counts, dominant and LEDs hold their previous values until start is accepted.
- SCAN: each cycle push valid=1 into a DET_LATENCY-deep shift register and increment mem_addr. On mem_addr==NUM_PIXELS-1, hold mem_addr at NUM_PIXELS-1 and go to DRAIN. mem_addr never wraps.
- DRAIN: push valid=0 for DET_LATENCY cycles, then go to DECIDE.
- Counting, in SCAN and DRAIN: when the valid pipe output is 1, increment each count whose flag is high. Flags are sampled exactly DET_LATENCY cycles after the corresponding address is presented. Multiple flags in one cycle increment all matching counters.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Exactly NUM_PIXELS samples are counted per scan. Scan length from start accept to done is NUM_PIXELS + DET_LATENCY + 2 cycles.
- DECIDE: dominant = colour whose count strictly exceeds both others; any tie for maximum -> 0. LEDs are registered from dominant in the same cycle. Go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- start while busy is ignored, with no queuing. start in the DONE cycle is also ignored.
- Reset mid-scan: aborts immediately; all outputs take their reset values.

Optional Feature:
- Macro COLOR_SCAN_THRESH_EN.
- Defined: adds input port min_count (CNT_W). In DECIDE, the winning colour is reported only if its count >= min_count; otherwise dominant=0. min_count is sampled at start accept and held for the whole scan.
- Undefined: no min_count port; any strict winner is reported.

Test Plan:
- Reset then start, frame of 256 red pixels (0xF800), DET_LATENCY=1 -> red_count=256, green_count=0, blue_count=0, dominant=1, red_led=1, done pulses exactly 259 cycles after start accept.
- Frame of 100 green (0x07E0), 100 blue (0x001F), 56 black pixels -> green_count=100, blue_count=100, dominant=0, all LEDs 0.
- start pulsed again at cycles 10 and 50 during a scan -> ignored, single done, counts unchanged from a single-scan reference. Then a back-to-back start after done clears counts and rescans with identical results.
- rst_n low at scan cycle 120, released, then start -> mem_addr restarts from 0, counts restart from 0, final results equal a clean scan.
- DET_LATENCY=3, alternating red/blue pixels -> red_count=128, blue_count=128; first flag counted 3 cycles after address 0; address holds at 255 through DRAIN.
- COLOR_SCAN_THRESH_EN, min_count=200, 150 red + 106 black pixels -> red_count=150, dominant=0. With min_count=150 -> dominant=1.
